if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage for the MIPS32 pipeline, the producer side of the decoder's `pc_i`/`inst_i` inputs. It holds the program counter and issues word fetches to instruction memory over a single-outstanding request/response interface. It registers each returned instruction with its PC into the IF/ID pipeline register, honouring downstream stall and branch/flush redirects. A one-entry skid register absorbs a response that arrives while ID is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  ID/EX cannot accept; hold `id_pc_o`/`id_inst_o`/`id_valid_o`.
- `flush_i`  in  1  redirect fetch to `flush_pc_i`; kill everything in flight.
- `flush_pc_i`  in  32  redirect target; bits [1:0] ignored (forced 0).
- `imem_req_o`  out  1  fetch request, level; held until response.
- `imem_addr_o`  out  32  fetch word address; stable while `imem_req_o`=1 and while waiting.
- `imem_rvalid_i`  in  1  response valid, one cycle, ≥1 cycle after request first seen.
- `imem_rdata_i`  in  32  instruction word, valid with `imem_rvalid_i`.
- `id_pc_o`  out  32  PC of instruction presented to ID.
- `id_inst_o`  out  32  instruction to ID; 32'h0 (NOP) whenever `id_valid_o`=0.
- `id_valid_o`  out  1  IF/ID register holds a live instruction.

## Operation
- State machine: IDLE, FETCH, HOLD, DROP.
- IDLE: entered on reset; `imem_req_o`=0; next cycle → FETCH.
- FETCH: `imem_req_o`=1, `imem_addr_o`=pc. On `imem_rvalid_i`:
  - IF/ID free (`!stall_i` or `!id_valid_o`): load {pc, rdata}, `id_valid_o`←1, pc←pc+4, stay FETCH (next request issues the following cycle).
  - IF/ID blocked (`stall_i` and `id_valid_o`): capture {pc, rdata} into skid, pc←pc+4, → HOLD.
  - No response and IF/ID free and `!stall_i`: `id_valid_o`←0 (bubble, `id_inst_o`=0).
- HOLD: `imem_req_o`=0. When `!stall_i`: skid → IF/ID, skid empty, → FETCH.
- DROP: `imem_req_o`=0, `imem_addr_o` held at killed address; wait for `imem_rvalid_i`, discard data, → FETCH (pc already redirected).
- Stall: while `stall_i`=1 and `id_valid_o`=1, IF/ID outputs unchanged bit-for-bit.
- Flush (priority over stall and response): `id_valid_o`←0, `id_inst_o`←0, skid cleared, pc←{flush_pc_i[31:2],2'b00}.
  - From FETCH with response outstanding and no `imem_rvalid_i` this cycle → DROP.
  - From FETCH with `imem_rvalid_i` this cycle → response discarded, → FETCH.
  - From HOLD or IDLE → FETCH.
  - In DROP: pc updated to new target, remain DROP.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Only one request outstanding ever; a new request never issues in the cycle its predecessor's response arrives except as the FETCH→FETCH continuation (next cycle).

## Timing
- Reset (sync): pc=`RESET_PC`, state=IDLE, skid empty, `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `id_pc_o`=0, `id_inst_o`=0, `id_valid_o`=0. Reset mid-fetch drops outstanding response: any `imem_rvalid_i` during IDLE is ignored.
- First request: cycle after reset deasserts +1 (IDLE one cycle).
- Fetch-to-ID latency: `imem_rvalid_i` at cycle N → `id_valid_o`=1 with that instruction at cycle N+1.
- Throughput with 1-cycle memory: one instruction every 2 cycles (req, rvalid).
- Flush at cycle N → `id_valid_o`=0 at N+1; new-target request at N+1 unless DROP.
- Stall release from HOLD at cycle N → skid instruction on outputs at N+1, next request at N+1.

## Test plan
- Reset, RESET_PC=32'h0000_0100, 1-cycle memory returning addr^32'hA5A5_0000 → ID sees PCs 0x100,0x104,0x108 with matching data, valid every other cycle, first at reset+3.
- Stall asserted while ID holds 0x104 and response for 0x108 arrives → outputs frozen at 0x104, req drops (HOLD); release → 0x108 next cycle, request for 0x10C follows.
- Flush to 32'h0000_2003 while 3-cycle-latency request outstanding → valid=0 next cycle, stale response discarded, next request addr=0x2000, ID sees 0x2000.
- Flush coincident with `imem_rvalid_i` and with `stall_i`=1 → response discarded, valid=0, next request to target, no DROP.
- PC wrap: flush to 0xFFFF_FFFC → ID sees 0xFFFF_FFFC then 0x0000_0000.
- Reset asserted in DROP and in HOLD → all outputs to reset values next cycle, late `imem_rvalid_i` ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request: req is a level held until the matching rvalid pulse.
interface if_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID register
// and a one-entry skid that absorbs a response arriving while ID is stalled.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   if_stage_if.master  imem,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] DROP  = 2'd3;

   logic [1:0]  state;
   logic [31:0] pc_p0;
   logic [31:0] kill_addr_p0;
   logic [31:0] skid_pc_p0;
   logic [31:0] skid_inst_p0;
   logic        skid_vld_p0;
   logic [31:0] pc_p1;
   logic [31:0] inst_p1;
   logic        vld_p1;

   logic        id_free;
   logic        rsp_take;
   logic        rsp_skid;
   logic        kill_fetch;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] pc_incr(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

   assign id_free    = !stall_i || !vld_p1;
   assign rsp_take   = (state == FETCH) && imem.imem_rvalid_i && !flush_i;
   assign rsp_skid   = rsp_take && !id_free;
   assign kill_fetch = (state == FETCH) && flush_i && !imem.imem_rvalid_i;

   assign imem.imem_req_o  = (state == FETCH);
   // A killed request keeps its address on the bus until its response drains.
   assign imem.imem_addr_o = (state == DROP) ? kill_addr_p0 : pc_p0;

   assign id_pc_o    = pc_p1;
   assign id_inst_o  = inst_p1;
   assign id_valid_o = vld_p1;

   // ---- p0: fetch control, PC and skid occupancy ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc_p0       <= RESET_PC;
         skid_vld_p0 <= 1'b0;
      end else if (flush_i) begin
         pc_p0       <= word_align(flush_pc_i);
         skid_vld_p0 <= 1'b0;
         if (kill_fetch || state == DROP) state <= DROP;
         else                             state <= FETCH;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (rsp_take) begin
                  pc_p0 <= pc_incr(pc_p0);
                  if (rsp_skid) begin
                     skid_vld_p0 <= 1'b1;
                     state       <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall_i && skid_vld_p0) begin
                  skid_vld_p0 <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: begin
               if (imem.imem_rvalid_i) state <= FETCH;
            end
         endcase
      end
   end

   // Skid contents and killed address are pure data; occupancy lives in the control block.
   always_ff @(posedge clk) begin
      if (rsp_skid) begin
         skid_pc_p0   <= pc_p0;
         skid_inst_p0 <= imem.imem_rdata_i;
      end
      if (kill_fetch) kill_addr_p0 <= pc_p0;
   end

   // ---- p1: IF/ID register; inst is forced to NOP whenever valid drops ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p1   <= 32'h0;
         inst_p1 <= 32'h0;
         vld_p1  <= 1'b0;
      end else if (flush_i) begin
         inst_p1 <= 32'h0;
         vld_p1  <= 1'b0;
      end else if (rsp_take && id_free) begin
         pc_p1   <= pc_p0;
         inst_p1 <= imem.imem_rdata_i;
         vld_p1  <= 1'b1;
      end else if (state == HOLD && !stall_i && skid_vld_p0) begin
         pc_p1   <= skid_pc_p0;
         inst_p1 <= skid_inst_p0;
         vld_p1  <= 1'b1;
      end else if (!stall_i) begin
         inst_p1 <= 32'h0;
         vld_p1  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-bench imem responder (data = addr ^ A5A5_0000)
// with per-request latency, scenario tasks with hand-computed expectations.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;

   if_stage_if imem ();

   if_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .flush_pc_i (flush_pc_i),
      .imem       (imem),
      .id_pc_o    (id_pc_o),
      .id_inst_o  (id_inst_o),
      .id_valid_o (id_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_run;
   int          n_fail;
   int          mem_lat;
   int          m_cnt;
   logic        m_busy;
   logic [31:0] m_addr;

   // Responder: accepts a request seen while idle, answers mem_lat cycles later.
   task automatic mem_model();
      imem.imem_rvalid_i = 1'b0;
      if (m_busy) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            imem.imem_rvalid_i = 1'b1;
            imem.imem_rdata_i  = m_addr ^ 32'hA5A5_0000;
            m_busy = 1'b0;
         end
      end else if (imem.imem_req_o) begin
         m_busy = 1'b1;
         m_cnt  = mem_lat;
         m_addr = imem.imem_addr_o;
      end
   endtask

   // One clock: outputs settle at posedge, sample and drive at the following negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      mem_model();
   endtask

   task automatic do_reset();
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
      m_busy = 1'b0; mem_lat = 1; imem.imem_rvalid_i = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
      m_busy = 1'b0; mem_lat = 1; imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = 32'h0;
      cyc();
      cyc();
      n_run++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem.imem_req_o); end
      n_run++; if (imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_addr: got %h want 00000100", imem.imem_addr_o); end
      n_run++; if (id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", id_pc_o); end
      n_run++; if (id_inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 00000000", id_inst_o); end
      n_run++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      cyc(); // c1
      n_run++; if (imem.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_req1: got %b want 1", imem.imem_req_o); end
      n_run++; if (imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL b2b_addr1: got %h want 00000100", imem.imem_addr_o); end
      cyc(); // c2
      n_run++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid2: got %b want 0", id_valid_o); end
      cyc(); // c3
      n_run++; if (id_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid3: got %b want 1", id_valid_o); end
      n_run++; if (id_pc_o !== 32'h0000_0100) begin n_fail++; $display("FAIL b2b_pc3: got %h want 00000100", id_pc_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_0100) begin n_fail++; $display("FAIL b2b_inst3: got %h want a5a50100", id_inst_o); end
      n_run++; if (imem.imem_addr_o !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_addr3: got %h want 00000104", imem.imem_addr_o); end
      cyc(); // c4
      n_run++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid4: got %b want 0", id_valid_o); end
      n_run++; if (id_inst_o !== 32'h0) begin n_fail++; $display("FAIL b2b_inst4: got %h want 00000000", id_inst_o); end
      cyc(); // c5
      n_run++; if (id_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid5: got %b want 1", id_valid_o); end
      n_run++; if (id_pc_o !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_pc5: got %h want 00000104", id_pc_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_0104) begin n_fail++; $display("FAIL b2b_inst5: got %h want a5a50104", id_inst_o); end
      cyc(); // c6
      n_run++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid6: got %b want 0", id_valid_o); end
      cyc(); // c7
      n_run++; if (id_pc_o !== 32'h0000_0108) begin n_fail++; $display("FAIL b2b_pc7: got %h want 00000108", id_pc_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_0108) begin n_fail++; $display("FAIL b2b_inst7: got %h want a5a50108", id_inst_o); end
   endtask

   task automatic test_stall_hold();
      do_reset();
      for (int i = 0; i < 5; i++) cyc(); // c5: ID holds 0x104, request 0x108 accepted
      stall_i = 1'b1;
      cyc(); // c6: response for 0x108 arrives
      n_run++; if (id_pc_o !== 32'h0000_0104 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_frz6: got pc %h v %b want 00000104 1", id_pc_o, id_valid_o); end
      n_run++; if (imem.imem_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL stall_rsp6: got %b want 1", imem.imem_rvalid_i); end
      cyc(); // c7: HOLD
      n_run++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req7: got %b want 0", imem.imem_req_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_0104 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_frz7: got inst %h v %b want a5a50104 1", id_inst_o, id_valid_o); end
      cyc(); // c8
      n_run++; if (id_pc_o !== 32'h0000_0104 || imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_frz8: got pc %h req %b want 00000104 0", id_pc_o, imem.imem_req_o); end
      stall_i = 1'b0;
      cyc(); // c9: skid on outputs, next request
      n_run++; if (id_pc_o !== 32'h0000_0108 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_rel_pc: got pc %h v %b want 00000108 1", id_pc_o, id_valid_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_0108) begin n_fail++; $display("FAIL stall_rel_inst: got %h want a5a50108", id_inst_o); end
      n_run++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0000_010C) begin n_fail++; $display("FAIL stall_rel_req: got req %b addr %h want 1 0000010c", imem.imem_req_o, imem.imem_addr_o); end
   endtask

   task automatic test_flush_drop();
      do_reset();
      cyc(); cyc(); // c2
      mem_lat = 3;
      cyc(); // c3: valid 0x100, request 0x104 accepted with 3-cycle latency
      stall_i = 1'b1;
      cyc(); // c4
      n_run++; if (id_pc_o !== 32'h0000_0100 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL fdrop_pre: got pc %h v %b want 00000100 1", id_pc_o, id_valid_o); end
      flush_i = 1'b1; flush_pc_i = 32'h0000_2003;
      cyc(); // c5: DROP
      flush_i = 1'b0; stall_i = 1'b0;
      n_run++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin n_fail++; $display("FAIL fdrop_kill: got v %b inst %h want 0 00000000", id_valid_o, id_inst_o); end
      n_run++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== 32'h0000_0104) begin n_fail++; $display("FAIL fdrop_bus5: got req %b addr %h want 0 00000104", imem.imem_req_o, imem.imem_addr_o); end
      mem_lat = 1;
      cyc(); // c6: stale response
      n_run++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL fdrop_req6: got %b want 0", imem.imem_req_o); end
      cyc(); // c7
      n_run++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL fdrop_stale: got v %b want 0", id_valid_o); end
      n_run++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL fdrop_newreq: got req %b addr %h want 1 00002000", imem.imem_req_o, imem.imem_addr_o); end
      cyc(); cyc(); // c9
      n_run++; if (id_pc_o !== 32'h0000_2000 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL fdrop_tgt_pc: got pc %h v %b want 00002000 1", id_pc_o, id_valid_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_2000) begin n_fail++; $display("FAIL fdrop_tgt_inst: got %h want a5a52000", id_inst_o); end
   endtask

   task automatic test_flush_rvalid();
      do_reset();
      cyc(); cyc(); cyc(); // c3: valid 0x100
      stall_i = 1'b1;
      cyc(); // c4: response for 0x104 present
      flush_i = 1'b1; flush_pc_i = 32'h0000_3000;
      cyc(); // c5
      flush_i = 1'b0; stall_i = 1'b0;
      n_run++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin n_fail++; $display("FAIL frv_kill: got v %b inst %h want 0 00000000", id_valid_o, id_inst_o); end
      n_run++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0000_3000) begin n_fail++; $display("FAIL frv_req: got req %b addr %h want 1 00003000", imem.imem_req_o, imem.imem_addr_o); end
      cyc(); cyc(); // c7
      n_run++; if (id_pc_o !== 32'h0000_3000 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL frv_pc: got pc %h v %b want 00003000 1", id_pc_o, id_valid_o); end
      n_run++; if (id_inst_o !== 32'hA5A5_3000) begin n_fail++; $display("FAIL frv_inst: got %h want a5a53000", id_inst_o); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      cyc(); cyc(); // c2: response for 0x100 present
      flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
      cyc(); // c3
      flush_i = 1'b0;
      n_run++; if (imem.imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got %h want fffffffc", imem.imem_addr_o); end
      cyc(); cyc(); // c5
      n_run++; if (id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== 32'h5A5A_FFFC) begin n_fail++; $display("FAIL wrap_top: got pc %h inst %h want fffffffc 5a5afffc", id_pc_o, id_inst_o); end
      n_run++; if (imem.imem_addr_o !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 00000000", imem.imem_addr_o); end
      cyc(); cyc(); // c7
      n_run++; if (id_pc_o !== 32'h0000_0000 || id_inst_o !== 32'hA5A5_0000 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got pc %h inst %h v %b want 00000000 a5a50000 1", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_reset_drop();
      do_reset();
      mem_lat = 2;
      cyc(); // c1: request 0x100 accepted
      flush_i = 1'b1; flush_pc_i = 32'h0000_0400;
      cyc(); // c2: DROP
      flush_i = 1'b0;
      n_run++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rdrop_drop: got req %b addr %h want 0 00000100", imem.imem_req_o, imem.imem_addr_o); end
      rst = 1'b1;
      cyc(); // c3: reset values, stale response presented
      n_run++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rdrop_bus: got req %b addr %h want 0 00000100", imem.imem_req_o, imem.imem_addr_o); end
      n_run++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rdrop_id: got pc %h inst %h v %b want 0 0 0", id_pc_o, id_inst_o, id_valid_o); end
      rst = 1'b0; mem_lat = 1;
      cyc(); // c4
      n_run++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdrop_late: got v %b want 0", id_valid_o); end
      n_run++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rdrop_restart: got req %b addr %h want 1 00000100", imem.imem_req_o, imem.imem_addr_o); end
      cyc(); cyc(); // c6
      n_run++; if (id_pc_o !== 32'h0000_0100 || id_inst_o !== 32'hA5A5_0100 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL rdrop_first: got pc %h inst %h v %b want 00000100 a5a50100 1", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_reset_hold();
      do_reset();
      cyc(); cyc(); cyc(); // c3: valid 0x100
      stall_i = 1'b1;
      cyc(); cyc(); // c5: HOLD
      n_run++; if (imem.imem_req_o !== 1'b0 || id_pc_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rhold_hold: got req %b pc %h want 0 00000100", imem.imem_req_o, id_pc_o); end
      rst = 1'b1;
      cyc(); // c6: reset values
      n_run++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rhold_id: got pc %h inst %h v %b want 0 0 0", id_pc_o, id_inst_o, id_valid_o); end
      n_run++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rhold_bus: got req %b addr %h want 0 00000100", imem.imem_req_o, imem.imem_addr_o); end
      rst = 1'b0; stall_i = 1'b0;
      imem.imem_rvalid_i = 1'b1; imem.imem_rdata_i = 32'hDEAD_BEEF;
      cyc(); // c7: late response was in IDLE
      n_run++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin n_fail++; $display("FAIL rhold_late: got v %b inst %h want 0 00000000", id_valid_o, id_inst_o); end
      n_run++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rhold_restart: got req %b addr %h want 1 00000100", imem.imem_req_o, imem.imem_addr_o); end
      cyc(); cyc(); // c9
      n_run++; if (id_pc_o !== 32'h0000_0100 || id_inst_o !== 32'hA5A5_0100 || id_valid_o !== 1'b1) begin n_fail++; $display("FAIL rhold_first: got pc %h inst %h v %b want 00000100 a5a50100 1", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      m_cnt = 0;
      m_addr = 32'h0;
      test_reset();
      test_back_to_back();
      test_stall_hold();
      test_flush_drop();
      test_flush_rvalid();
      test_pc_wrap();
      test_reset_drop();
      test_reset_hold();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
